// File: rtl/dispatch_queue_if.sv
// Decode-side and functional-unit-side signal bundle for dispatch_queue.
// slave is the dispatch stage; master is the decode/functional-unit environment.
interface dispatch_queue_if #(
    parameter int unsigned ISSUE_W     = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned ARITH_UNITS = 2,
    parameter int unsigned OP_W        = 16,
    parameter int unsigned OPC_W       = 7,
    parameter int unsigned WB_W        = 5
) ();
    logic [ISSUE_W-1:0]                 enable_i;
    logic [2*ISSUE_W-1:0]               functionalType_i;
    logic [ISSUE_W-1:0]                 isWb_i;
    logic [WB_W*ISSUE_W-1:0]            wbAddress_i;
    logic [OPC_W*ISSUE_W-1:0]           opCode_i;
    logic [OP_W*ISSUE_W-1:0]            pOperand_i;
    logic [OP_W*ISSUE_W-1:0]            sOperand_i;
    logic                               inReady_o;
    logic [$clog2(QUEUE_DEPTH):0]       count_o;

    logic [ARITH_UNITS-1:0]             arithReady_i;
    logic                               lsReady_i;
    logic                               branchReady_i;
    logic                               regReady_i;

    logic [ARITH_UNITS-1:0]             arithValid_o;
    logic [ARITH_UNITS-1:0]             arithIsWb_o;
    logic [WB_W*ARITH_UNITS-1:0]        arithWbAddress_o;
    logic [OPC_W*ARITH_UNITS-1:0]       arithOpCode_o;
    logic [OP_W*ARITH_UNITS-1:0]        arithPOperand_o;
    logic [OP_W*ARITH_UNITS-1:0]        arithSOperand_o;

    logic                               lsValid_o;
    logic                               lsIsWb_o;
    logic [WB_W-1:0]                    lsWbAddress_o;
    logic [OPC_W-1:0]                   lsOpCode_o;
    logic [OP_W-1:0]                    lsPOperand_o;
    logic [OP_W-1:0]                    lsSOperand_o;

    logic                               branchValid_o;
    logic [OPC_W-1:0]                   branchOpCode_o;
    logic [OP_W-1:0]                    branchPOperand_o;
    logic [OP_W-1:0]                    branchSOperand_o;

    logic                               regValid_o;
    logic [OPC_W-1:0]                   regOpCode_o;

    modport master (
        output enable_i, functionalType_i, isWb_i, wbAddress_i, opCode_i,
               pOperand_i, sOperand_i,
               arithReady_i, lsReady_i, branchReady_i, regReady_i,
        input  inReady_o, count_o,
               arithValid_o, arithIsWb_o, arithWbAddress_o, arithOpCode_o,
               arithPOperand_o, arithSOperand_o,
               lsValid_o, lsIsWb_o, lsWbAddress_o, lsOpCode_o, lsPOperand_o, lsSOperand_o,
               branchValid_o, branchOpCode_o, branchPOperand_o, branchSOperand_o,
               regValid_o, regOpCode_o
    );

    modport slave (
        input  enable_i, functionalType_i, isWb_i, wbAddress_i, opCode_i,
               pOperand_i, sOperand_i,
               arithReady_i, lsReady_i, branchReady_i, regReady_i,
        output inReady_o, count_o,
               arithValid_o, arithIsWb_o, arithWbAddress_o, arithOpCode_o,
               arithPOperand_o, arithSOperand_o,
               lsValid_o, lsIsWb_o, lsWbAddress_o, lsOpCode_o, lsPOperand_o, lsSOperand_o,
               branchValid_o, branchOpCode_o, branchPOperand_o, branchSOperand_o,
               regValid_o, regOpCode_o
    );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch stage: circular queue of decoded instructions issued in program
// order to arithmetic, load/store, branch and reg-stack channels with back-pressure.
module dispatch_queue #(
    parameter int unsigned ISSUE_W     = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned ARITH_UNITS = 2,
    parameter int unsigned OP_W        = 16,
    parameter int unsigned OPC_W       = 7,
    parameter int unsigned WB_W        = 5
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            flush_i,
    dispatch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        FT_ARITH = 2'd0,
        FT_LS    = 2'd1,
        FT_BR    = 2'd2,
        FT_RG    = 2'd3
    } ftype_e;

    typedef struct packed {
        ftype_e           ftype;
        logic             is_wb;
        logic [WB_W-1:0]  wb;
        logic [OPC_W-1:0] opc;
        logic [OP_W-1:0]  pop;
        logic [OP_W-1:0]  sop;
    } entry_t;

    entry_t        mem_q [QUEUE_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    entry_t        lane   [ISSUE_W];
    logic [PW-1:0] wr_idx [ISSUE_W];
    logic [CW-1:0] n_enq, enq_cnt, n_iss, n_arith;
    logic          in_ready, do_enq;

    entry_t        ent;
    logic          go, stop, arith_ok, ls_used, br_used, rg_used;

    logic [ARITH_UNITS-1:0]       a_valid_q, a_valid_d, a_iswb_q, a_iswb_d;
    logic [WB_W*ARITH_UNITS-1:0]  a_wb_q, a_wb_d;
    logic [OPC_W*ARITH_UNITS-1:0] a_opc_q, a_opc_d;
    logic [OP_W*ARITH_UNITS-1:0]  a_pop_q, a_pop_d, a_sop_q, a_sop_d;

    logic             ls_valid_q, ls_valid_d, ls_iswb_q, ls_iswb_d;
    logic [WB_W-1:0]  ls_wb_q, ls_wb_d;
    logic [OPC_W-1:0] ls_opc_q, ls_opc_d;
    logic [OP_W-1:0]  ls_pop_q, ls_pop_d, ls_sop_q, ls_sop_d;

    logic             br_valid_q, br_valid_d;
    logic [OPC_W-1:0] br_opc_q, br_opc_d;
    logic [OP_W-1:0]  br_pop_q, br_pop_d, br_sop_q, br_sop_d;

    logic             rg_valid_q, rg_valid_d;
    logic [OPC_W-1:0] rg_opc_q, rg_opc_d;

    // Free space is judged on the registered count only, never on same-cycle issue.
    assign in_ready = (CW'(QUEUE_DEPTH) - count_q) >= CW'(ISSUE_W);
    assign do_enq   = in_ready & ~flush_i;
    assign enq_cnt  = do_enq ? n_enq : '0;

    // Enabled lanes are compacted onto consecutive tail slots, lane 0 first.
    always_comb begin
        n_enq = '0;
        for (int unsigned l = 0; l < ISSUE_W; l++) begin
            lane[l].ftype = ftype_e'(bus.functionalType_i[2*l +: 2]);
            lane[l].is_wb = bus.isWb_i[l];
            lane[l].wb    = bus.wbAddress_i[WB_W*l +: WB_W];
            lane[l].opc   = bus.opCode_i[OPC_W*l +: OPC_W];
            lane[l].pop   = bus.pOperand_i[OP_W*l +: OP_W];
            lane[l].sop   = bus.sOperand_i[OP_W*l +: OP_W];
            wr_idx[l]     = tail_q + n_enq[PW-1:0];
            if (bus.enable_i[l]) n_enq = n_enq + CW'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_enq) begin
            for (int unsigned l = 0; l < ISSUE_W; l++) begin
                if (bus.enable_i[l]) mem_q[wr_idx[l]] <= lane[l];
            end
        end
    end

    always_comb begin
        a_valid_d  = '0;
        a_iswb_d   = a_iswb_q;
        a_wb_d     = a_wb_q;
        a_opc_d    = a_opc_q;
        a_pop_d    = a_pop_q;
        a_sop_d    = a_sop_q;
        ls_valid_d = 1'b0;
        ls_iswb_d  = ls_iswb_q;
        ls_wb_d    = ls_wb_q;
        ls_opc_d   = ls_opc_q;
        ls_pop_d   = ls_pop_q;
        ls_sop_d   = ls_sop_q;
        br_valid_d = 1'b0;
        br_opc_d   = br_opc_q;
        br_pop_d   = br_pop_q;
        br_sop_d   = br_sop_q;
        rg_valid_d = 1'b0;
        rg_opc_d   = rg_opc_q;
        ent        = '0;
        go         = 1'b0;
        arith_ok   = 1'b0;
        n_iss      = '0;
        n_arith    = '0;
        ls_used    = 1'b0;
        br_used    = 1'b0;
        rg_used    = 1'b0;
        stop       = flush_i;

        // Scan oldest entries; the first one that cannot go ends the scan.
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            ent = mem_q[head_q + PW'(k)];
            go  = 1'b0;
            if (!stop && (CW'(k) < count_q)) begin
                unique case (ent.ftype)
                    FT_ARITH: begin
                        arith_ok = 1'b0;
                        for (int unsigned j = 0; j < ARITH_UNITS; j++) begin
                            if (CW'(j) == n_arith) arith_ok = bus.arithReady_i[j];
                        end
                        go = arith_ok;
                        if (go) begin
                            for (int unsigned j = 0; j < ARITH_UNITS; j++) begin
                                if (CW'(j) == n_arith) begin
                                    a_valid_d[j]                = 1'b1;
                                    a_iswb_d[j]                 = ent.is_wb;
                                    a_wb_d[WB_W*j +: WB_W]      = ent.wb;
                                    a_opc_d[OPC_W*j +: OPC_W]   = ent.opc;
                                    a_pop_d[OP_W*j +: OP_W]     = ent.pop;
                                    a_sop_d[OP_W*j +: OP_W]     = ent.sop;
                                end
                            end
                            n_arith = n_arith + CW'(1);
                        end
                    end
                    FT_LS: begin
                        go = !ls_used && bus.lsReady_i;
                        if (go) begin
                            ls_used    = 1'b1;
                            ls_valid_d = 1'b1;
                            ls_iswb_d  = ent.is_wb;
                            ls_wb_d    = ent.wb;
                            ls_opc_d   = ent.opc;
                            ls_pop_d   = ent.pop;
                            ls_sop_d   = ent.sop;
                        end
                    end
                    FT_BR: begin
                        go = !br_used && bus.branchReady_i;
                        if (go) begin
                            br_used    = 1'b1;
                            br_valid_d = 1'b1;
                            br_opc_d   = ent.opc;
                            br_pop_d   = ent.pop;
                            br_sop_d   = ent.sop;
                        end
                    end
                    FT_RG: begin
                        go = !rg_used && bus.regReady_i;
                        if (go) begin
                            rg_used    = 1'b1;
                            rg_valid_d = 1'b1;
                            rg_opc_d   = ent.opc;
                        end
                    end
                endcase
            end
            if (go) n_iss = n_iss + CW'(1);
            else    stop  = 1'b1;
            if (go && ent.ftype == FT_BR) stop = 1'b1;
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_iss[PW-1:0];
            tail_d  = tail_q + enq_cnt[PW-1:0];
            count_d = count_q + enq_cnt - n_iss;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            a_valid_q  <= '0;
            a_iswb_q   <= '0;
            a_wb_q     <= '0;
            a_opc_q    <= '0;
            a_pop_q    <= '0;
            a_sop_q    <= '0;
            ls_valid_q <= 1'b0;
            ls_iswb_q  <= 1'b0;
            ls_wb_q    <= '0;
            ls_opc_q   <= '0;
            ls_pop_q   <= '0;
            ls_sop_q   <= '0;
            br_valid_q <= 1'b0;
            br_opc_q   <= '0;
            br_pop_q   <= '0;
            br_sop_q   <= '0;
            rg_valid_q <= 1'b0;
            rg_opc_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            a_valid_q  <= a_valid_d;
            a_iswb_q   <= a_iswb_d;
            a_wb_q     <= a_wb_d;
            a_opc_q    <= a_opc_d;
            a_pop_q    <= a_pop_d;
            a_sop_q    <= a_sop_d;
            ls_valid_q <= ls_valid_d;
            ls_iswb_q  <= ls_iswb_d;
            ls_wb_q    <= ls_wb_d;
            ls_opc_q   <= ls_opc_d;
            ls_pop_q   <= ls_pop_d;
            ls_sop_q   <= ls_sop_d;
            br_valid_q <= br_valid_d;
            br_opc_q   <= br_opc_d;
            br_pop_q   <= br_pop_d;
            br_sop_q   <= br_sop_d;
            rg_valid_q <= rg_valid_d;
            rg_opc_q   <= rg_opc_d;
        end
    end

    assign bus.inReady_o        = in_ready;
    assign bus.count_o          = count_q;
    assign bus.arithValid_o     = a_valid_q;
    assign bus.arithIsWb_o      = a_iswb_q;
    assign bus.arithWbAddress_o = a_wb_q;
    assign bus.arithOpCode_o    = a_opc_q;
    assign bus.arithPOperand_o  = a_pop_q;
    assign bus.arithSOperand_o  = a_sop_q;
    assign bus.lsValid_o        = ls_valid_q;
    assign bus.lsIsWb_o         = ls_iswb_q;
    assign bus.lsWbAddress_o    = ls_wb_q;
    assign bus.lsOpCode_o       = ls_opc_q;
    assign bus.lsPOperand_o     = ls_pop_q;
    assign bus.lsSOperand_o     = ls_sop_q;
    assign bus.branchValid_o    = br_valid_q;
    assign bus.branchOpCode_o   = br_opc_q;
    assign bus.branchPOperand_o = br_pop_q;
    assign bus.branchSOperand_o = br_sop_q;
    assign bus.regValid_o       = rg_valid_q;
    assign bus.regOpCode_o      = rg_opc_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: per-cycle vector table plus directed
// sequences for back-pressure, wrap-around ordering, flush and asynchronous reset.
module tb_dispatch_queue;
    localparam int IW = 2, QD = 8, AU = 2, OPW = 16, OCW = 7, WBW = 5;
    localparam logic [4:0] R = 5'h1f;

    typedef struct {
        logic [1:0] en;
        logic [3:0] ft;
        logic [6:0] o0, o1;
        logic [4:0] rdy;     // {arith[1:0], ls, branch, reg}
        logic       fl;
        logic [1:0] x_aval;
        logic [6:0] x_a0, x_a1;
        logic       x_ls;
        logic [6:0] x_lsop;
        logic       x_br;
        logic [6:0] x_brop;
        logic       x_rg;
        logic [6:0] x_rgop;
        logic [3:0] x_cnt;
        logic       x_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    vec_t       vt [25];
    logic [6:0] q_exp [$];
    logic [6:0] e_opc;
    logic [1:0] ar;
    logic       accept;
    int         sent, cyc;
    int         x_cnt4 [4];

    dispatch_queue_if #(.ISSUE_W(IW), .QUEUE_DEPTH(QD), .ARITH_UNITS(AU),
                        .OP_W(OPW), .OPC_W(OCW), .WB_W(WBW)) bus ();

    dispatch_queue #(.ISSUE_W(IW), .QUEUE_DEPTH(QD), .ARITH_UNITS(AU),
                     .OP_W(OPW), .OPC_W(OCW), .WB_W(WBW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic [3:0] ft, input logic [6:0] o0,
                         input logic [6:0] o1, input logic [4:0] rdy, input logic fl);
        bus.enable_i         = en;
        bus.functionalType_i = ft;
        bus.opCode_i         = {o1, o0};
        bus.pOperand_i       = {16'h1000 + 16'(o1), 16'h1000 + 16'(o0)};
        bus.sOperand_i       = {16'h2000 + 16'(o1), 16'h2000 + 16'(o0)};
        bus.wbAddress_i      = {o1[4:0], o0[4:0]};
        bus.isWb_i           = {o1[0], o0[0]};
        bus.arithReady_i     = rdy[4:3];
        bus.lsReady_i        = rdy[2];
        bus.branchReady_i    = rdy[1];
        bus.regReady_i       = rdy[0];
        flush                = fl;
    endtask

    initial begin
        //       en     ft    o0     o1     rdy       fl    aval   a0     a1     ls    lsop   br    brop   rg    rgop   cnt   rdy
        vt[0]  = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[1]  = '{2'b11, 4'h0, 7'h05, 7'h06, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[2]  = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b11, 7'h05, 7'h06, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[3]  = '{2'b11, 4'hA, 7'h11, 7'h12, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[4]  = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h11, 1'b0, 7'h00, 4'd1, 1'b1};
        vt[5]  = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h12, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[6]  = '{2'b11, 4'h1, 7'h21, 7'h22, 5'b11011, 1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[7]  = '{2'b00, 4'h0, 7'h00, 7'h00, 5'b11011, 1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[8]  = '{2'b00, 4'h0, 7'h00, 7'h00, 5'b11011, 1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[9]  = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b01, 7'h22, 7'h00, 1'b1, 7'h21, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[10] = '{2'b11, 4'hB, 7'h31, 7'h32, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[11] = '{2'b11, 4'h0, 7'h33, 7'h34, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h32, 1'b1, 7'h31, 4'd2, 1'b1};
        vt[12] = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b11, 7'h33, 7'h34, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[13] = '{2'b11, 4'h0, 7'h41, 7'h42, 5'b10111, 1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[14] = '{2'b00, 4'h0, 7'h00, 7'h00, 5'b10111, 1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[15] = '{2'b00, 4'h0, 7'h00, 7'h00, 5'b01111, 1'b0, 2'b01, 7'h41, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd1, 1'b1};
        vt[16] = '{2'b00, 4'h0, 7'h00, 7'h00, 5'b01111, 1'b0, 2'b01, 7'h42, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[17] = '{2'b11, 4'h5, 7'h51, 7'h52, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[18] = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 7'h51, 1'b0, 7'h00, 1'b0, 7'h00, 4'd1, 1'b1};
        vt[19] = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 7'h52, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[20] = '{2'b10, 4'h0, 7'h61, 7'h62, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd1, 1'b1};
        vt[21] = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b01, 7'h62, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[22] = '{2'b11, 4'h0, 7'h71, 7'h72, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd2, 1'b1};
        vt[23] = '{2'b11, 4'h0, 7'h73, 7'h74, R,        1'b1, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};
        vt[24] = '{2'b00, 4'h0, 7'h00, 7'h00, R,        1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 4'd0, 1'b1};

        drive(2'b00, 4'h0, 7'h00, 7'h00, R, 1'b0);
        #1;
        chk("reset aval",   32'(bus.arithValid_o), 32'h0);
        chk("reset aopc",   32'(bus.arithOpCode_o), 32'h0);
        chk("reset lsval",  32'(bus.lsValid_o), 32'h0);
        chk("reset brval",  32'(bus.branchValid_o), 32'h0);
        chk("reset rgval",  32'(bus.regValid_o), 32'h0);
        chk("reset count",  32'(bus.count_o), 32'h0);
        chk("reset inrdy",  32'(bus.inReady_o), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].en, vt[i].ft, vt[i].o0, vt[i].o1, vt[i].rdy, vt[i].fl);
            tick();
            chk($sformatf("v%0d aval", i), 32'(bus.arithValid_o), 32'(vt[i].x_aval));
            if (vt[i].x_aval[0]) begin
                chk($sformatf("v%0d a0opc", i), 32'(bus.arithOpCode_o[6:0]), 32'(vt[i].x_a0));
                chk($sformatf("v%0d a0pop", i), 32'(bus.arithPOperand_o[15:0]), 32'(16'h1000 + 16'(vt[i].x_a0)));
            end
            if (vt[i].x_aval[1])
                chk($sformatf("v%0d a1opc", i), 32'(bus.arithOpCode_o[13:7]), 32'(vt[i].x_a1));
            chk($sformatf("v%0d lsval", i), 32'(bus.lsValid_o), 32'(vt[i].x_ls));
            if (vt[i].x_ls) begin
                chk($sformatf("v%0d lsopc", i), 32'(bus.lsOpCode_o), 32'(vt[i].x_lsop));
                chk($sformatf("v%0d lswb", i), 32'(bus.lsWbAddress_o), 32'(vt[i].x_lsop[4:0]));
            end
            chk($sformatf("v%0d brval", i), 32'(bus.branchValid_o), 32'(vt[i].x_br));
            if (vt[i].x_br)
                chk($sformatf("v%0d bropc", i), 32'(bus.branchOpCode_o), 32'(vt[i].x_brop));
            chk($sformatf("v%0d rgval", i), 32'(bus.regValid_o), 32'(vt[i].x_rg));
            if (vt[i].x_rg)
                chk($sformatf("v%0d rgopc", i), 32'(bus.regOpCode_o), 32'(vt[i].x_rgop));
            chk($sformatf("v%0d count", i), 32'(bus.count_o), 32'(vt[i].x_cnt));
            chk($sformatf("v%0d inrdy", i), 32'(bus.inReady_o), 32'(vt[i].x_rdy));
        end

        // Back-pressure: fill to 7 with arith units stalled, then drain two per cycle.
        drive(2'b01, 4'h0, 7'h10, 7'h7f, 5'b00111, 1'b0);
        tick();
        chk("bp count1", 32'(bus.count_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 4'h0, 7'(7'h11 + 7'(2*i)), 7'(7'h12 + 7'(2*i)), 5'b00111, 1'b0);
            tick();
            chk($sformatf("bp fill count %0d", i), 32'(bus.count_o), 32'(3 + 2*i));
            chk($sformatf("bp fill inrdy %0d", i), 32'(bus.inReady_o), (i == 2) ? 32'd0 : 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 4'h0, 7'h70, 7'h71, 5'b00111, 1'b0);
            tick();
            chk($sformatf("bp hold count %0d", i), 32'(bus.count_o), 32'd7);
            chk($sformatf("bp hold inrdy %0d", i), 32'(bus.inReady_o), 32'd0);
            chk($sformatf("bp hold aval %0d", i), 32'(bus.arithValid_o), 32'd0);
        end
        x_cnt4 = '{5, 3, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 4'h0, 7'h00, 7'h00, R, 1'b0);
            tick();
            chk($sformatf("bp drain count %0d", i), 32'(bus.count_o), 32'(x_cnt4[i]));
            chk($sformatf("bp drain aval %0d", i), 32'(bus.arithValid_o), (i == 3) ? 32'h1 : 32'h3);
            chk($sformatf("bp drain a0 %0d", i), 32'(bus.arithOpCode_o[6:0]), 32'(7'h10 + 7'(2*i)));
            if (i < 3)
                chk($sformatf("bp drain a1 %0d", i), 32'(bus.arithOpCode_o[13:7]), 32'(7'h11 + 7'(2*i)));
        end

        // Wrap-around: 20 arith pairs with random single-cycle ready drops; order must hold.
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || q_exp.size() != 0) && cyc < 300) begin
            ar = 2'b11;
            if ($urandom_range(0, 3) == 0) ar[$urandom_range(0, 1)] = 1'b0;
            if (sent < 40)
                drive(2'b11, 4'h0, 7'(7'h40 + 7'(sent)), 7'(7'h41 + 7'(sent)), {ar, 3'b111}, 1'b0);
            else
                drive(2'b00, 4'h0, 7'h00, 7'h00, {ar, 3'b111}, 1'b0);
            accept = (sent < 40) && bus.inReady_o;
            tick();
            cyc++;
            if (accept) begin
                q_exp.push_back(7'(7'h40 + 7'(sent)));
                q_exp.push_back(7'(7'h41 + 7'(sent)));
                sent += 2;
            end
            for (int ch = 0; ch < AU; ch++) begin
                if (bus.arithValid_o[ch]) begin
                    if (q_exp.size() == 0) begin
                        chk($sformatf("wrap spurious ch%0d", ch), 32'(bus.arithOpCode_o[ch*7 +: 7]), 32'hffff_ffff);
                    end else begin
                        e_opc = q_exp.pop_front();
                        chk($sformatf("wrap order ch%0d", ch), 32'(bus.arithOpCode_o[ch*7 +: 7]), 32'(e_opc));
                    end
                end
            end
            chk("wrap count", 32'(bus.count_o), 32'(q_exp.size()));
        end
        chk("wrap sent", 32'(sent), 32'd40);
        chk("wrap left", 32'(q_exp.size()), 32'd0);

        // Flush with five entries queued.
        drive(2'b01, 4'h0, 7'h20, 7'h7f, 5'b00111, 1'b0);
        tick();
        drive(2'b11, 4'h0, 7'h21, 7'h22, 5'b00111, 1'b0);
        tick();
        drive(2'b11, 4'h0, 7'h23, 7'h24, 5'b00111, 1'b0);
        tick();
        chk("flush pre count", 32'(bus.count_o), 32'd5);
        drive(2'b11, 4'h0, 7'h25, 7'h26, R, 1'b1);
        tick();
        chk("flush count", 32'(bus.count_o), 32'd0);
        chk("flush aval", 32'(bus.arithValid_o), 32'd0);
        chk("flush inrdy", 32'(bus.inReady_o), 32'd1);
        drive(2'b00, 4'h0, 7'h00, 7'h00, R, 1'b0);
        tick();
        chk("post flush count", 32'(bus.count_o), 32'd0);
        chk("post flush aval", 32'(bus.arithValid_o), 32'd0);

        // Asynchronous reset mid-stream.
        drive(2'b11, 4'h0, 7'h30, 7'h31, R, 1'b0);
        tick();
        drive(2'b11, 4'h0, 7'h32, 7'h33, R, 1'b0);
        tick();
        chk("pre rst aval", 32'(bus.arithValid_o), 32'h3);
        chk("pre rst count", 32'(bus.count_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async rst aval", 32'(bus.arithValid_o), 32'h0);
        chk("async rst aopc", 32'(bus.arithOpCode_o), 32'h0);
        chk("async rst apop", 32'(bus.arithPOperand_o), 32'h0);
        chk("async rst count", 32'(bus.count_o), 32'd0);
        chk("async rst inrdy", 32'(bus.inReady_o), 32'd1);
        tick();
        chk("held rst count", 32'(bus.count_o), 32'd0);
        chk("held rst inrdy", 32'(bus.inReady_o), 32'd1);
        @(negedge clk) rst = 1'b0;
        drive(2'b01, 4'h0, 7'h35, 7'h00, R, 1'b0);
        tick();
        chk("after rst count", 32'(bus.count_o), 32'd1);
        drive(2'b00, 4'h0, 7'h00, 7'h00, R, 1'b0);
        tick();
        chk("after rst aval", 32'(bus.arithValid_o), 32'h1);
        chk("after rst a0", 32'(bus.arithOpCode_o[6:0]), 32'h35);
        chk("after rst count0", 32'(bus.count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised in-order dispatch stage between decode and the functional units. It buffers up to ISSUE_W decoded instructions per cycle in a circular queue and issues them in program order, up to ISSUE_W per cycle. Each instruction goes to one of ARITH_UNITS arithmetic channels, one load/store channel, one branch channel or one reg-stack channel, with per-unit ready back-pressure. Structural conflicts, such as two branches in one cycle, stall dispatch instead of overwriting.

## Interface
- ISSUE_W, 2: instructions accepted and dispatched per cycle (1..4).
- QUEUE_DEPTH, 8: queue entries; power of 2, ≥ 2*ISSUE_W.
- ARITH_UNITS, 2: arithmetic channels (1..ISSUE_W).
- OP_W, 16: operand width. OPC_W, 7: opcode width. WB_W, 5: writeback address width.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous queue flush.
- enable_i  in  ISSUE_W  per-lane instruction valid; lane 0 is oldest.
- functionalType_i  in  2*ISSUE_W  per lane: 0 arith, 1 load/store, 2 branch, 3 reg-stack.
- isWb_i  in  ISSUE_W; wbAddress_i  in  WB_W*ISSUE_W; opCode_i  in  OPC_W*ISSUE_W; pOperand_i, sOperand_i  in  OP_W*ISSUE_W  per-lane fields.
- inReady_o  out  1  queue can accept a full ISSUE_W group this cycle.
- count_o  out  clog2(QUEUE_DEPTH)+1  current occupancy.
- arithReady_i  in  ARITH_UNITS; lsReady_i, branchReady_i, regReady_i  in  1  unit can take an instruction next cycle.
- arithValid_o  out  ARITH_UNITS; arithIsWb_o  out  ARITH_UNITS; arithWbAddress_o  out  WB_W*ARITH_UNITS; arithOpCode_o  out  OPC_W*ARITH_UNITS; arithPOperand_o, arithSOperand_o  out  OP_W*ARITH_UNITS.
- lsValid_o  out  1; lsIsWb_o  out  1; lsWbAddress_o  out  WB_W; lsOpCode_o  out  OPC_W; lsPOperand_o, lsSOperand_o  out  OP_W.
- branchValid_o  out  1; branchOpCode_o  out  OPC_W; branchPOperand_o, branchSOperand_o  out  OP_W.
- regValid_o  out  1; regOpCode_o  out  OPC_W.

## Operation
- Enqueue:
  - `inReady_o = (QUEUE_DEPTH − count) ≥ ISSUE_W`. It is combinational from the registered count and never depends on same-cycle dispatch.
  - At each edge with inReady_o=1, every lane with enable_i set is written at the tail, lowest lane first. Lanes are compacted: enable=2'b10 writes one entry.
  - When inReady_o=0, inputs are ignored. Decode must hold them.
- Dispatch decision:
  - Each cycle, examine the oldest min(count, ISSUE_W) entries in order.
  - Entry k issues only if entry k−1 issued this cycle (strict in-order) and its resource is free.
  - Arithmetic: the j-th arith entry this cycle takes channel j. It needs j < ARITH_UNITS and arithReady_i[j].
  - Load/store, branch, reg-stack: at most one each per cycle. Each needs its ready input.
  - A branch issues last in its cycle; no younger entry issues alongside it.
  - The first blocked entry stops the scan.
- Output registers:
  - At the edge, issued entries load their channel registers and set the corresponding valid.
  - All other valids clear. Valids are one-cycle pulses.
  - Data registers of unused channels hold their previous value.
  - The head pointer advances by the issued count.
- Pointers wrap modulo QUEUE_DEPTH.
- count_next = count + enqueued − issued. Simultaneous enqueue and dispatch is legal.
- flush_i=1 at an edge:
  - count and pointers reset to 0.
  - No dispatch; all valids 0 next cycle.
  - Same-cycle inputs are discarded.
  - Flush has priority over enqueue and dispatch.
- Reset (asynchronous):
  - Pointers and count = 0; all valid outputs and all data outputs = 0.
  - inReady_o=1 during and after reset.
  - Reset mid-operation drops queued entries immediately.

## Timing
- Minimum latency: input captured at edge n gives output valid after edge n+1. There is no bypass, so an empty queue still costs one cycle.
- Ready inputs are sampled in the decision cycle. The issued instruction is valid the following cycle.
- Throughput is ISSUE_W per cycle when there are no resource conflicts.
- count_o and inReady_o update one edge after the causing event.

## Test plan
- **Basic dual arith:** defaults, all readies 1; cycle 0 enable=2'b11, both type 0, opcodes 7'h05/7'h06 → cycle 2 arithValid_o=2'b11 with opcodes 05 (ch0) and 06 (ch1); count_o returns to 0.
- **Branch conflict:** two type-2 entries in one group → cycle 2 branchValid_o=1 with the lane-0 opcode only; cycle 3 branchValid_o=1 with the lane-1 opcode.
- **Back-pressure:**
  - Fill with arith instructions while arithReady_i=0 → inReady_o falls to 0 at count=7 (free slots 1 < ISSUE_W). Further enables are ignored and count_o stays ≤ 8.
  - Raise arithReady_i=2'b11 → drains 2 per cycle in order.
- **Head blocking:** queue [load/store, arith] with lsReady_i=0, arithReady_i=1 → no valids until lsReady_i=1. Then lsValid_o precedes or accompanies arithValid_o, never follows it.
- **Wrap-around:** stream 20 consecutive arith pairs with random single-cycle ready drops → output opcode order exactly matches input order.
- **Flush/reset:** flush_i with count_o=5 → next cycle count_o=0 and no valids. Assert reset_i mid-stream → all outputs 0 asynchronously and inReady_o=1.
